// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel solver datapath.
package gsim_pkg;

    localparam int unsigned GSIM_N   = 16;
    localparam int unsigned SOL_W    = 32;
    localparam int unsigned SOL_FRAC = 16;

    // Read-side sequencer of the result sink.
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // One solver output word, signed Q16.16.
    typedef logic [SOL_W-1:0] sol_word_t;

endpackage

// File: rtl/gsim_result_sink_q_round_sat.sv
// Fixed-point re-quantiser: round half toward +inf, then saturate to OUT_W bits.
module q_round_sat #(
    parameter int unsigned IN_W     = 32,
    parameter int unsigned IN_FRAC  = 16,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned OUT_FRAC = 4
)(
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data_c,
    output logic             o_sat_c
);

    localparam int unsigned SHIFT = IN_FRAC - OUT_FRAC;
    localparam int unsigned EXT_W = IN_W + 1;

    // One extra bit keeps the rounding add from overflowing.
    localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shr;

    // Sign-extend, add half an output LSB, arithmetic shift, clip.
    always_comb begin
        w_ext    = {i_data[IN_W-1], i_data};
        w_sum    = w_ext + HALF;
        w_shr    = w_sum >>> SHIFT;
        o_data_c = w_shr[OUT_W-1:0];
        o_sat_c  = 1'b0;
        if (w_shr > MAX_V) begin
            o_data_c = MAX_V[OUT_W-1:0];
            o_sat_c  = 1'b1;
        end else if (w_shr < MIN_V) begin
            o_data_c = MIN_V[OUT_W-1:0];
            o_sat_c  = 1'b1;
        end
    end

endmodule

// File: rtl/gsim_result_sink.sv
// Captures solver solution vectors into a ping-pong buffer and streams them
// out over valid/ready so the solver never waits on the consumer.
module gsim_result_sink
    import gsim_pkg::*;
#(
    parameter int unsigned N        = GSIM_N,
    parameter int unsigned OUT_W    = 16,
    parameter int unsigned OUT_FRAC = 4
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sol_valid,
    input  sol_word_t            sol_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_W-1:0]     m_data,
    output logic [$clog2(N)-1:0] m_index,
    output logic                 m_last,
    output logic                 err_drop,
    output logic                 sat_flag,
    output logic [7:0]           frame_cnt
);

    localparam int unsigned      IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Write side
    logic             r_cap_en;
    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_frame_ok;
    logic             r_err_drop;
    logic             r_sat_flag;
    logic [7:0]       r_frame_cnt;

    // Storage and occupancy
    logic [OUT_W-1:0] r_bank [2][N];
    logic [1:0]       r_full;

    // Read side
    rd_state_t        r_state;
    logic             r_rd_bank;
    logic [IDX_W-1:0] r_rd_idx;

    logic [OUT_W-1:0] w_conv;
    logic             w_conv_sat;
    logic             w_handshake;
    logic             w_free;
    logic             w_frame_start;
    logic             w_tgt_full;
    logic             w_word_ok;
    logic             w_wr_en;
    logic             w_wr_done;
    logic [1:0]       w_bank_ready;

    q_round_sat #(
        .IN_W     (SOL_W),
        .IN_FRAC  (SOL_FRAC),
        .OUT_W    (OUT_W),
        .OUT_FRAC (OUT_FRAC)
    ) u_conv (
        .i_data   (sol_data),
        .o_data_c (w_conv),
        .o_sat_c  (w_conv_sat)
    );

    // Outputs come straight from state, read index and the bank mux.
    assign m_valid   = (r_state == RD_STREAM);
    assign m_index   = r_rd_idx;
    assign m_last    = m_valid && (r_rd_idx == LAST_IDX);
    assign m_data    = m_valid ? r_bank[r_rd_bank][r_rd_idx] : '0;
    assign err_drop  = r_err_drop;
    assign sat_flag  = r_sat_flag;
    assign frame_cnt = r_frame_cnt;

    // Handshake, bank free, and the accept decision for the current word.
    always_comb begin
        w_handshake   = m_valid && m_ready;
        w_free        = w_handshake && m_last;
        w_frame_start = r_cap_en && (r_wr_idx == '0);
        // A bank released this very cycle counts as empty for a new frame.
        w_tgt_full    = r_full[r_wr_bank] && !(w_free && (r_rd_bank == r_wr_bank));
        w_word_ok     = (r_wr_idx == '0) ? !w_tgt_full : r_frame_ok;
        w_wr_en       = r_cap_en && w_word_ok;
        w_wr_done     = w_wr_en && (r_wr_idx == LAST_IDX);
        // Banks that will hold a complete frame after this edge.
        w_bank_ready  = r_full;
        if (w_wr_done) begin
            w_bank_ready[r_wr_bank] = 1'b1;
        end
    end

    // Align the capture strobe with the word the solver presents a cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_en <= 1'b0;
        end else begin
            r_cap_en <= sol_valid;
        end
    end

    // Write counters, frame accept tracking and sticky status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_frame_ok  <= 1'b0;
            r_err_drop  <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else if (r_cap_en) begin
            // Index advances even for dropped frames so boundaries stay aligned.
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            if (w_frame_start) begin
                r_frame_ok <= !w_tgt_full;
                if (w_tgt_full) begin
                    r_err_drop <= 1'b1;
                end
            end
            if (w_wr_en && w_conv_sat) begin
                r_sat_flag <= 1'b1;
            end
            if (w_wr_done) begin
                r_wr_bank   <= ~r_wr_bank;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Ping-pong storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(N); i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_wr_en) begin
            r_bank[r_wr_bank][r_wr_idx] <= w_conv;
        end
    end

    // Bank occupancy: set by the last captured word, cleared by the last handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_done && (r_wr_bank == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_free && (r_rd_bank == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    // Read sequencer: stream the oldest full bank, chain banks without a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RD_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (w_bank_ready[r_rd_bank]) begin
                        r_state <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (m_ready) begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_rd_bank <= ~r_rd_bank;
                            r_rd_idx  <= '0;
                            r_state   <= w_bank_ready[~r_rd_bank] ? RD_STREAM : RD_IDLE;
                        end else begin
                            r_rd_idx <= r_rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gsim_result_sink.md
# gsim_result_sink

Downstream stage of the Gauss-Seidel solver. It captures each 16-word solution vector the solver emits during its SEND phase. Each Q16.16 word is converted to a rounded, saturated signed fixed-point value of parameterised format, and the vector is stored in a ping-pong buffer. The block then streams the vector out over a valid/ready interface, so the solver never stalls while the consumer applies backpressure.

## Interface
- `N`, 16, words per solution vector (power of 2)
- `OUT_W`, 16, output word width (signed)
- `OUT_FRAC`, 4, output fractional bits (1..15); input fractional bits fixed at 16
- `clk` in 1, clock
- `reset` in 1, asynchronous, active-high
- `sol_valid` in 1, solver out_valid (high N consecutive cycles per vector)
- `sol_data` in 32, solver x_out, signed Q16.16; word k is presented one cycle after the k-th `sol_valid` cycle
- `m_valid` out 1, output word valid
- `m_ready` in 1, consumer accept
- `m_data` out OUT_W, converted word
- `m_index` out log2(N), word index within vector
- `m_last` out 1, high with index N-1
- `err_drop` out 1, sticky: a vector was dropped because both banks were full
- `sat_flag` out 1, sticky: at least one captured word saturated
- `frame_cnt` out 8, vectors accepted into the buffer, wraps at 255

## Operation
- **Alignment:** `sol_valid` is registered once to `cap_en`. Capture happens when `cap_en`=1, using the current `sol_data`.
- **Conversion** (`S` = 16−OUT_FRAC):
  - Sign-extend `sol_data` to 33 bits and add 2^(S−1).
  - Arithmetic shift right by S. This rounds half toward +inf.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Any clip sets `sat_flag`.
- **Write side:**
  - `wr_bank` and `wr_idx` select the target location.
  - A frame starts on `cap_en` with `wr_idx`=0. If the target bank is full at frame start, the entire frame is discarded: `err_drop` is set, `wr_idx` still counts so the frame boundary is tracked, and `frame_cnt` is unchanged.
  - Each accepted word is written to `bank[wr_bank][wr_idx]`.
  - After word N−1 is written: `full[wr_bank]` is set, `wr_bank` toggles, and `frame_cnt` increments.
  - Gaps in `cap_en` mid-frame pause capture. There is no timeout.
- **Read FSM**, states IDLE and STREAM:
  - IDLE → STREAM when `full[rd_bank]`=1.
  - In STREAM, `m_valid`=1 and `m_data`=`bank[rd_bank][rd_idx]`.
  - On each `m_valid`&&`m_ready`, `rd_idx` increments.
  - On the handshake with `m_last`: clear `full[rd_bank]`, toggle `rd_bank`, and reset `rd_idx` to 0. Go to STREAM if the other bank is full, otherwise IDLE. There is no idle bubble between back-to-back frames.
- **Simultaneous free and frame start:** if bank X is freed on the same cycle a frame targeting bank X starts, the frame is accepted. The free takes priority in the full-check.
- **Stability:** while `m_valid`&&!`m_ready`, `m_data`, `m_index`, and `m_last` hold stable.
- **Reset,** including mid-frame or mid-stream:
  - All state, counters, flags, and `full` bits are cleared.
  - Partially captured data is discarded.
  - Outputs reset to: `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, `err_drop`=0, `sat_flag`=0, `frame_cnt`=0.

## Timing
- Word 0 is captured at the end of T+1, where T is the first `sol_valid` cycle. Word N−1 is captured at the end of T+N.
- `m_valid` rises in cycle T+N+1 with index 0. Latency from first `sol_valid` to first output is N+1 cycles.
- Throughput is one word per cycle on each side. Capture and streaming run concurrently on opposite banks.
- Output signals are driven from registers (bank array, `rd_idx`, and state) through the bank/index mux only. There is no combinational path from `m_ready` to `m_valid`.
- Buffering holds at most 2 full vectors. A 3rd vector arriving with zero drain is dropped.

## Structure
- Shared package `gsim_pkg` holds:
  - `GSIM_N`=16, `SOL_W`=32, `SOL_FRAC`=16
  - read FSM state enum
  - solution-word typedef
- Sub-module `q_round_sat` is purely combinational and performs the 33-bit add, shift, and saturate. It is parameterised by IN_W, IN_FRAC, OUT_W, and OUT_FRAC, and outputs the value plus a sat bit.
- The top module holds the ping-pong banks (2×N×OUT_W registers), the write counters, and the read FSM.

## Test plan
- **Single frame, `m_ready`=1:** drive x_k = k<<16 for k=0..15. Expect `m_data` = k<<4, `m_index`=k, and `m_last` only at k=15. `m_valid` first rises at T+17. `frame_cnt`=1.
- **Rounding and saturation:**
  - 0x00010800 → 17
  - 0xFFFFF800 → 0
  - 0x00000801 → 1
  - 0x7FFF0000 → 0x7FFF with `sat_flag`=1
  - 0x80000000 → 0x8000
- **Backpressure overflow:** hold `m_ready`=0 and send 3 frames (A, B, C). Expect `err_drop`=1 and `frame_cnt`=2. Then raise `m_ready`: A is output then B, with no gap between them. C never appears.
- **`m_ready` toggling every other cycle:** outputs hold while stalled. All 16 words arrive in order exactly once.
- **Reset after 7 words of a frame:**
  - All outputs are 0 during reset.
  - The next full frame is captured from index 0.
  - Output matches the new frame only.
- **Simultaneous free and frame start:** both banks are full, and the last-word handshake of bank A coincides with the first capture of a new frame. The frame is accepted into A, and `err_drop` stays 0.
